// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, sequential advance, redirect with
// misalignment trap, and a halt/resume state.
module pc_gen #(
    parameter int unsigned           XLEN         = 64,
    parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'('h100),
    parameter int unsigned           BOOT_DELAY   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_plus4,
    output logic            trap_pulse,
    output logic [XLEN-1:0] bad_target
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    localparam logic [3:0]      BOOT_LAST = 4'(BOOT_DELAY - 1);
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic            trap_q, trap_d;
    logic            valid_q;
    logic            misaligned;

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        trap_d  = 1'b0;
        case (state_q)
            S_BOOT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == BOOT_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (halt) state_d = S_HALT;
                if (!redirect && !halt && !stall && fetch_ready) pc_d = pc_q + FOUR;
            end
            S_HALT: begin
                if (resume && !halt) state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
        // Redirect wins over hold/advance in both RUN and HALT.
        if (redirect && (state_q == S_RUN || state_q == S_HALT)) begin
            if (misaligned) begin
                pc_d   = TRAP_VECTOR;
                bad_d  = redirect_pc;
                trap_d = 1'b1;
            end else begin
                pc_d   = redirect_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            cnt_q   <= '0;
            pc_q    <= RESET_VECTOR;
            bad_q   <= '0;
            trap_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            trap_q  <= trap_d;
            valid_q <= (state_d == S_RUN);
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = valid_q;
    assign pc_plus4   = pc_q + FOUR;
    assign trap_pulse = trap_q;
    assign bad_target = bad_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomized + directed bench for pc_gen; a cycle-level reference model feeds
// a scoreboard queue that a negedge monitor drains.
module tb_pc_gen;
    localparam int          BOOT_DELAY = 2;
    localparam logic [63:0] RV   = 64'h0;
    localparam logic [63:0] TV   = 64'h100;

    logic        clk = 1'b0;
    logic        reset, stall, fetch_ready, redirect, halt, resume;
    logic [63:0] redirect_pc;
    logic [63:0] pc, pc_plus4, bad_target;
    logic        pc_valid, trap_pulse;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(64), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_DELAY(BOOT_DELAY)) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .resume(resume),
        .pc(pc), .pc_valid(pc_valid), .pc_plus4(pc_plus4),
        .trap_pulse(trap_pulse), .bad_target(bad_target)
    );

    typedef struct {
        logic [63:0] pc;
        logic        valid;
        logic        trap;
        logic [63:0] bad;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: mode 0=boot 1=run 2=halt, boot tracked as cycles spent.
    int          m_mode = 0;
    int          m_boot = 0;
    logic [63:0] m_pc   = '0;
    logic [63:0] m_bad  = '0;
    logic        m_trap = 1'b0;

    task automatic model_step();
        int next_mode;
        m_trap = 1'b0;
        if (reset) begin
            m_mode = 0; m_boot = 0; m_pc = RV; m_bad = '0;
            return;
        end
        next_mode = m_mode;
        if (m_mode == 0) begin
            m_boot++;
            if (m_boot == BOOT_DELAY) next_mode = 1;
        end else begin
            if (m_mode == 1 && halt) next_mode = 2;
            if (m_mode == 2 && resume && !halt) next_mode = 1;
            if (redirect) begin
                if (redirect_pc % 4 != 0) begin
                    m_pc = TV; m_bad = redirect_pc; m_trap = 1'b1;
                end else m_pc = redirect_pc;
            end else if (m_mode == 1 && !halt && !stall && fetch_ready)
                m_pc = m_pc + 64'd4;
        end
        m_mode = next_mode;
    endtask

    task automatic cyc(input logic rs, st, fr, rd, input logic [63:0] rpc,
                       input logic h, rsm);
        exp_t e;
        reset = rs; stall = st; fetch_ready = fr; redirect = rd;
        redirect_pc = rpc; halt = h; resume = rsm;
        @(posedge clk);
        model_step();
        e.pc = m_pc; e.valid = (m_mode == 1); e.trap = m_trap; e.bad = m_bad;
        sbq.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 64'h0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_pc_plus4", pc_plus4, e.pc + 64'd4);
            chk("sb_valid", {63'b0, pc_valid}, {63'b0, e.valid});
            chk("sb_trap", {63'b0, trap_pulse}, {63'b0, e.trap});
            chk("sb_bad", bad_target, e.bad);
        end
    end

    initial begin
        logic [63:0] t;
        reset = 1'b0; stall = 1'b0; fetch_ready = 1'b1; redirect = 1'b0;
        redirect_pc = '0; halt = 1'b0; resume = 1'b0;
        @(posedge clk); #1;

        // Boot sequence and first fetches
        cyc(1, 0, 1, 0, 64'h0, 0, 0);
        chk("rst_valid", {63'b0, pc_valid}, 64'd0);
        chk("rst_pc", pc, RV);
        chk("rst_bad", bad_target, 64'h0);
        cyc(0, 1, 0, 1, 64'h300, 1, 1);   // BOOT ignores everything
        chk("boot_valid", {63'b0, pc_valid}, 64'd0);
        chk("boot_pc", pc, RV);
        idle(1);
        chk("run_pc0", pc, 64'h0);
        chk("run_valid", {63'b0, pc_valid}, 64'd1);
        idle(1); chk("run_pc4", pc, 64'h4);
        idle(1); chk("run_pc8", pc, 64'h8);

        // Hold via stall then via fetch_ready
        cyc(0, 0, 1, 1, 64'h40, 0, 0);
        chk("redir_40", pc, 64'h40);
        for (int i = 0; i < 3; i++) begin cyc(0, 1, 1, 0, 64'h0, 0, 0); chk("stall_hold", pc, 64'h40); end
        for (int i = 0; i < 2; i++) begin cyc(0, 0, 0, 0, 64'h0, 0, 0); chk("fr_hold", pc, 64'h40); end
        idle(1); chk("after_hold", pc, 64'h44);

        // Redirect during stall, aligned and misaligned
        cyc(0, 1, 1, 1, 64'h200, 0, 0); chk("redir_stall", pc, 64'h200);
        cyc(0, 1, 1, 1, 64'h202, 0, 0);
        chk("trap_pc", pc, TV);
        chk("trap_bad", bad_target, 64'h202);
        chk("trap_hi", {63'b0, trap_pulse}, 64'd1);
        cyc(0, 1, 1, 0, 64'h0, 0, 0);
        chk("trap_lo", {63'b0, trap_pulse}, 64'd0);

        // Wrap at top of address space
        cyc(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        chk("plus4_top", pc_plus4, 64'h0);
        idle(1);
        chk("wrap_pc", pc, 64'h0);
        chk("wrap_plus4", pc_plus4, 64'h4);

        // halt+redirect, halt+resume, resume
        cyc(0, 0, 1, 1, 64'h80, 1, 0);
        chk("hr_pc", pc, 64'h80);
        chk("hr_valid", {63'b0, pc_valid}, 64'd0);
        cyc(0, 0, 1, 0, 64'h0, 1, 1);
        chk("halt_resume_stay", {63'b0, pc_valid}, 64'd0);
        idle(1); chk("halt_pc", pc, 64'h80);
        cyc(0, 0, 1, 0, 64'h0, 0, 1);
        chk("resume_valid", {63'b0, pc_valid}, 64'd1);
        chk("resume_pc", pc, 64'h80);
        idle(1); chk("resume_adv", pc, 64'h84);

        // Reset while halted with a pending misaligned redirect
        cyc(0, 0, 1, 0, 64'h0, 1, 0);
        cyc(1, 0, 1, 1, 64'h203, 0, 0);
        chk("rst_halt_pc", pc, RV);
        chk("rst_halt_trap", {63'b0, trap_pulse}, 64'd0);
        chk("rst_halt_valid", {63'b0, pc_valid}, 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            t = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
            else t[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) t[63:8] = '1;
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, t,
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end

        @(posedge clk); @(posedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
